multi_hit_encoder: RTL and testbench

//  Parametrised sequential successor to the combinational 8-to-3 priority encoder.
//  On Start, latches a WIDTH-bit request vector and emits the index of every set bit,
//   one per valid/ready handshake, lowest index first.

---
 rtl/multi_hit_encoder_if.sv | 59 +++++
 rtl/multi_hit_encoder.sv | 157 +++++++++++++++
 tb/tb_multi_hit_encoder.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/multi_hit_encoder_if.sv
// ---------------------------------------------------------------------------
// multi_hit_encoder_if
//   Bundles the control, request and index-stream signals of
//   multi_hit_encoder. clk/rst are kept as plain module ports.
//
//   Optional macro: MULTI_HIT_COUNT_EN adds the registered popcount output
//   'count'.
//
//   Signals:
//     en     global enable/hold (0 freezes the encoder)
//     start  load req and begin a scan (accepted only when idle)
//     req    request vector, bit 0 = highest priority
//     ready  consumer accepts y this cycle
//     valid  y holds a valid index
//     y      index of the lowest pending request bit
//     last   with valid: y is the final pending index
//     busy   scan in progress
//     done   one-cycle completion pulse
//     empty  with done: the latched vector was all-zero
//     count  (MULTI_HIT_COUNT_EN) number of set bits in the latched vector
//
//   Modports: master = request source / consumer side, slave = encoder.
// ---------------------------------------------------------------------------
interface multi_hit_encoder_if #(
  parameter int WIDTH = 8,
  parameter int IDXW  = 3
);
  logic             en;
  logic             start;
  logic [WIDTH-1:0] req;
  logic             ready;
  logic             valid;
  logic [IDXW-1:0]  y;
  logic             last;
  logic             busy;
  logic             done;
  logic             empty;
`ifdef MULTI_HIT_COUNT_EN
  logic [IDXW:0]    count;

  modport master (
    output en, start, req, ready,
    input  valid, y, last, busy, done, empty, count
  );
  modport slave (
    input  en, start, req, ready,
    output valid, y, last, busy, done, empty, count
  );
`else
  modport master (
    output en, start, req, ready,
    input  valid, y, last, busy, done, empty
  );
  modport slave (
    input  en, start, req, ready,
    output valid, y, last, busy, done, empty
  );
`endif
endinterface

// File: rtl/multi_hit_encoder.sv
// ---------------------------------------------------------------------------
// multi_hit_encoder
//   Sequential multi-hit priority encoder. On an accepted start the WIDTH-bit
//   request vector is latched and the index of every set bit is streamed out,
//   lowest index first, one per valid/ready handshake. A one-cycle done pulse
//   marks completion; empty accompanies done when the vector was all-zero.
//
//   Parameters:
//     WIDTH  request vector width (>= 2)
//     IDXW   index width, WIDTH <= 2**IDXW
//
//   Ports:
//     clk   sole clock, rising edge
//     rst   synchronous active-high reset, overrides everything
//     bus   multi_hit_encoder_if.slave (see interface file for signals)
//
//   Optional macro: MULTI_HIT_COUNT_EN adds bus.count, the popcount of the
//   vector captured on the most recent accepted start.
// ---------------------------------------------------------------------------
module multi_hit_encoder #(
  parameter int WIDTH = 8,
  parameter int IDXW  = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  multi_hit_encoder_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] pending_reg;
  logic [IDXW-1:0]  y_reg;
  logic             last_reg;
  logic             emit_reg;
  logic             busy_reg;
  logic             done_reg;
  logic             empty_reg;
  logic [WIDTH-1:0] pending_next;

  // Index of the lowest set bit; 0 for an all-zero vector.
  function automatic logic [IDXW-1:0] lowest_idx(input logic [WIDTH-1:0] v);
    lowest_idx = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (v[i]) lowest_idx = IDXW'(i);
    end
  endfunction

  // True when exactly one bit is set.
  function automatic logic is_one_hot(input logic [WIDTH-1:0] v);
    is_one_hot = (v != '0) && ((v & (v - WIDTH'(1))) == '0);
  endfunction

  // Pending vector with the currently presented index removed.
  assign pending_next = pending_reg & ~(WIDTH'(1) << y_reg);

`ifdef MULTI_HIT_COUNT_EN
  logic [IDXW:0] count_reg;

  function automatic logic [IDXW:0] popcount(input logic [WIDTH-1:0] v);
    popcount = '0;
    for (int i = 0; i < WIDTH; i++) begin
      popcount = popcount + (IDXW+1)'(v[i]);
    end
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
    end else if (bus.en && bus.start && (state_reg == IDLE)) begin
      count_reg <= popcount(bus.req);
    end
  end

  assign bus.count = count_reg;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      pending_reg <= '0;
      y_reg       <= '0;
      last_reg    <= 1'b0;
      emit_reg    <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      empty_reg   <= 1'b0;
    end else if (bus.en) begin
      // With en low every register holds, which freezes the scan in place.
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            pending_reg <= bus.req;
            busy_reg    <= 1'b1;
            if (bus.req != '0) begin
              state_reg <= EMIT;
              emit_reg  <= 1'b1;
              y_reg     <= lowest_idx(bus.req);
              last_reg  <= is_one_hot(bus.req);
            end else begin
              state_reg <= FIN;
              done_reg  <= 1'b1;
              empty_reg <= 1'b1;
            end
          end
        end

        EMIT: begin
          // en is high here, so valid is high and ready alone completes
          // the handshake.
          if (bus.ready) begin
            pending_reg <= pending_next;
            if (last_reg) begin
              state_reg <= FIN;
              emit_reg  <= 1'b0;
              last_reg  <= 1'b0;
              done_reg  <= 1'b1;
            end else begin
              // Next index is precomputed so it appears the very next cycle.
              y_reg    <= lowest_idx(pending_next);
              last_reg <= is_one_hot(pending_next);
            end
          end
        end

        FIN: begin
          state_reg <= IDLE;
          done_reg  <= 1'b0;
          empty_reg <= 1'b0;
          busy_reg  <= 1'b0;
        end

        default: begin
          state_reg <= IDLE;
          emit_reg  <= 1'b0;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
          empty_reg <= 1'b0;
        end
      endcase
    end
  end

  // done/empty are held in their registers while en is low and only shown
  // once en returns, so the pulse is deferred rather than stretched.
  assign bus.valid = emit_reg & bus.en;
  assign bus.done  = done_reg & bus.en;
  assign bus.empty = empty_reg & bus.en;
  assign bus.y     = y_reg;
  assign bus.last  = last_reg;
  assign bus.busy  = busy_reg;

endmodule

// File: tb/tb_multi_hit_encoder.sv
// ---------------------------------------------------------------------------
// tb_multi_hit_encoder
//   Directed bench for multi_hit_encoder: an 8-bit instance for the main
//   scenarios and a 16-bit instance for the wide-vector case. Inputs change
//   1 time unit after the rising edge; outputs are checked at that point.
// ---------------------------------------------------------------------------
module tb_multi_hit_encoder;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  multi_hit_encoder_if #(.WIDTH(8),  .IDXW(3)) bus8 ();
  multi_hit_encoder_if #(.WIDTH(16), .IDXW(4)) bus16 ();

  multi_hit_encoder #(.WIDTH(8), .IDXW(3)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8.slave)
  );

  multi_hit_encoder #(.WIDTH(16), .IDXW(4)) dut16 (
    .clk (clk),
    .rst (rst),
    .bus (bus16.slave)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      bus8.start  = 1'($urandom_range(0, 1));
      bus8.req    = 8'($urandom);
      bus16.start = 1'($urandom_range(0, 1));
      bus16.req   = 16'($urandom);
      tick();
    end
    checks++; if (bus8.valid !== 1'b0) $display("FAIL reset_valid got %b want 0", bus8.valid); else passed++;
    checks++; if (bus8.y !== 3'd0) $display("FAIL reset_y got %0d want 0", bus8.y); else passed++;
    checks++; if (bus8.done !== 1'b0) $display("FAIL reset_done got %b want 0", bus8.done); else passed++;
    checks++; if (bus8.busy !== 1'b0) $display("FAIL reset_busy got %b want 0", bus8.busy); else passed++;
    checks++; if (bus8.empty !== 1'b0) $display("FAIL reset_empty got %b want 0", bus8.empty); else passed++;
    checks++; if (bus16.valid !== 1'b0) $display("FAIL reset_valid16 got %b want 0", bus16.valid); else passed++;
    rst = 1'b0;
    bus8.start  = 1'b0;
    bus16.start = 1'b0;
    tick();
    $display("reset: done");
  endtask

  task automatic test_scan();
    logic [2:0] exp_y [3];
    exp_y[0] = 3'd2; exp_y[1] = 3'd5; exp_y[2] = 3'd7;
    bus8.req   = 8'b1010_0100;
    bus8.start = 1'b1;
    bus8.ready = 1'b1;
    tick();
    bus8.start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checks++; if (bus8.valid !== 1'b1) $display("FAIL scan_valid[%0d] got %b want 1", k, bus8.valid); else passed++;
      checks++; if (bus8.y !== exp_y[k]) $display("FAIL scan_y[%0d] got %0d want %0d", k, bus8.y, exp_y[k]); else passed++;
      checks++; if (bus8.last !== (k == 2)) $display("FAIL scan_last[%0d] got %b want %b", k, bus8.last, (k == 2)); else passed++;
      checks++; if (bus8.busy !== 1'b1) $display("FAIL scan_busy[%0d] got %b want 1", k, bus8.busy); else passed++;
      checks++; if (bus8.done !== 1'b0) $display("FAIL scan_early_done[%0d] got %b want 0", k, bus8.done); else passed++;
      tick();
    end
    checks++; if (bus8.done !== 1'b1) $display("FAIL scan_done got %b want 1", bus8.done); else passed++;
    checks++; if (bus8.valid !== 1'b0) $display("FAIL scan_fin_valid got %b want 0", bus8.valid); else passed++;
    checks++; if (bus8.busy !== 1'b1) $display("FAIL scan_fin_busy got %b want 1", bus8.busy); else passed++;
    checks++; if (bus8.empty !== 1'b0) $display("FAIL scan_fin_empty got %b want 0", bus8.empty); else passed++;
    tick();
    checks++; if (bus8.done !== 1'b0) $display("FAIL scan_done_pulse got %b want 0", bus8.done); else passed++;
    checks++; if (bus8.busy !== 1'b0) $display("FAIL scan_idle_busy got %b want 0", bus8.busy); else passed++;
    $display("scan: req=a4 indices 2,5,7 checked");
  endtask

  task automatic test_backpressure();
    bus8.req   = 8'h81;
    bus8.start = 1'b1;
    bus8.ready = 1'b0;
    tick();
    bus8.start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checks++; if (bus8.valid !== 1'b1) $display("FAIL bp_valid[%0d] got %b want 1", k, bus8.valid); else passed++;
      checks++; if (bus8.y !== 3'd0) $display("FAIL bp_y[%0d] got %0d want 0", k, bus8.y); else passed++;
      checks++; if (bus8.last !== 1'b0) $display("FAIL bp_last[%0d] got %b want 0", k, bus8.last); else passed++;
      tick();
    end
    bus8.ready = 1'b1;
    tick();
    checks++; if (bus8.y !== 3'd7) $display("FAIL bp_y7 got %0d want 7", bus8.y); else passed++;
    checks++; if (bus8.last !== 1'b1) $display("FAIL bp_last7 got %b want 1", bus8.last); else passed++;
    checks++; if (bus8.valid !== 1'b1) $display("FAIL bp_valid7 got %b want 1", bus8.valid); else passed++;
    tick();
    checks++; if (bus8.done !== 1'b1) $display("FAIL bp_done got %b want 1", bus8.done); else passed++;
    tick();
    $display("backpressure: req=81 held then drained");
  endtask

  task automatic test_empty();
    bus8.req   = 8'h00;
    bus8.start = 1'b1;
    bus8.ready = 1'b1;
    tick();
    bus8.start = 1'b0;
    checks++; if (bus8.done !== 1'b1) $display("FAIL empty_done got %b want 1", bus8.done); else passed++;
    checks++; if (bus8.empty !== 1'b1) $display("FAIL empty_flag got %b want 1", bus8.empty); else passed++;
    checks++; if (bus8.valid !== 1'b0) $display("FAIL empty_valid got %b want 0", bus8.valid); else passed++;
    tick();
    checks++; if (bus8.done !== 1'b0) $display("FAIL empty_done_pulse got %b want 0", bus8.done); else passed++;
    checks++; if (bus8.empty !== 1'b0) $display("FAIL empty_flag_pulse got %b want 0", bus8.empty); else passed++;
    checks++; if (bus8.valid !== 1'b0) $display("FAIL empty_valid2 got %b want 0", bus8.valid); else passed++;
    $display("empty: req=00 done+empty single cycle");
  endtask

  task automatic test_enable_hold();
    bus8.req   = 8'hFF;
    bus8.start = 1'b1;
    bus8.ready = 1'b1;
    tick();
    bus8.start = 1'b0;
    checks++; if (bus8.y !== 3'd0) $display("FAIL hold_y0 got %0d want 0", bus8.y); else passed++;
    tick();
    checks++; if (bus8.y !== 3'd1) $display("FAIL hold_y1 got %0d want 1", bus8.y); else passed++;
    tick();
    bus8.en = 1'b0;
    #1;
    checks++; if (bus8.valid !== 1'b0) $display("FAIL hold_valid_off got %b want 0", bus8.valid); else passed++;
    bus8.start = 1'b1;
    bus8.req   = 8'h01;
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++; if (bus8.valid !== 1'b0) $display("FAIL hold_valid[%0d] got %b want 0", k, bus8.valid); else passed++;
      checks++; if (bus8.y !== 3'd2) $display("FAIL hold_y[%0d] got %0d want 2", k, bus8.y); else passed++;
      checks++; if (bus8.busy !== 1'b1) $display("FAIL hold_busy[%0d] got %b want 1", k, bus8.busy); else passed++;
    end
    bus8.en = 1'b1;
    #1;
    checks++; if (bus8.valid !== 1'b1) $display("FAIL hold_resume_valid got %b want 1", bus8.valid); else passed++;
    checks++; if (bus8.y !== 3'd2) $display("FAIL hold_resume_y got %0d want 2", bus8.y); else passed++;
    tick();
    bus8.start = 1'b0;
    checks++; if (bus8.y !== 3'd3) $display("FAIL hold_ignored_start got %0d want 3", bus8.y); else passed++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (bus8.valid !== 1'b0) $display("FAIL midrst_valid got %b want 0", bus8.valid); else passed++;
    checks++; if (bus8.y !== 3'd0) $display("FAIL midrst_y got %0d want 0", bus8.y); else passed++;
    checks++; if (bus8.busy !== 1'b0) $display("FAIL midrst_busy got %b want 0", bus8.busy); else passed++;
    checks++; if (bus8.last !== 1'b0) $display("FAIL midrst_last got %b want 0", bus8.last); else passed++;
    checks++; if (bus8.done !== 1'b0) $display("FAIL midrst_done got %b want 0", bus8.done); else passed++;
    tick();
    checks++; if (bus8.valid !== 1'b0) $display("FAIL midrst_stays_idle got %b want 0", bus8.valid); else passed++;
    $display("enable_hold: freeze, ignored start, resume, mid-scan reset");
  endtask

  task automatic test_wide();
    bus16.req   = 16'h8001;
    bus16.start = 1'b1;
    bus16.ready = 1'b1;
    tick();
    bus16.start = 1'b0;
    checks++; if (bus16.valid !== 1'b1) $display("FAIL wide_valid got %b want 1", bus16.valid); else passed++;
    checks++; if (bus16.y !== 4'd0) $display("FAIL wide_y0 got %0d want 0", bus16.y); else passed++;
    checks++; if (bus16.last !== 1'b0) $display("FAIL wide_last0 got %b want 0", bus16.last); else passed++;
`ifdef MULTI_HIT_COUNT_EN
    checks++; if (bus16.count !== 5'd2) $display("FAIL wide_count got %0d want 2", bus16.count); else passed++;
`endif
    tick();
    checks++; if (bus16.y !== 4'd15) $display("FAIL wide_y15 got %0d want 15", bus16.y); else passed++;
    checks++; if (bus16.last !== 1'b1) $display("FAIL wide_last15 got %b want 1", bus16.last); else passed++;
    tick();
    checks++; if (bus16.done !== 1'b1) $display("FAIL wide_done got %b want 1", bus16.done); else passed++;
    tick();
    checks++; if (bus16.busy !== 1'b0) $display("FAIL wide_idle got %b want 0", bus16.busy); else passed++;
    $display("wide: req=8001 indices 0,15 checked");
  endtask

  initial begin
    rst = 1'b1;
    bus8.en  = 1'b1; bus8.start  = 1'b0; bus8.req  = '0; bus8.ready  = 1'b0;
    bus16.en = 1'b1; bus16.start = 1'b0; bus16.req = '0; bus16.ready = 1'b0;
    #1;
    test_reset();
    test_scan();
    test_backpressure();
    test_empty();
    test_enable_hold();
    test_wide();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
